// File: rtl/pwm_multi.sv
// ---------------------------------------------------------------------------
// pwm_multi -- bank of NUM_CH independent PWM generators behind a small
// register interface.
//
// Each channel has four registers, addressed as {channel, reg}:
//   reg 0 CTRL   : bit0 EN, bit1 POL (1 = active-low), bit2 IRQ_CLR (write-only)
//   reg 1 PERIOD : counter period in ticks (0 = channel parked at inactive level)
//   reg 2 DUTY   : number of ticks per period the output is active
//   reg 3 PRESC  : prescaler terminal value, one tick every PRESC+1 clocks
// PERIOD/DUTY/PRESC writes land in pending shadow registers.  The active copies
// reload only at a period wrap or while the channel is disabled, so a running
// waveform never changes shape mid-period.
//
// Ports:
//   clk_i          rising-edge clock for all logic
//   rst_i          synchronous active-high reset
//   reg_we_i       register write strobe (one write per asserted cycle)
//   reg_addr_i     {channel index, register index}; channels >= NUM_CH ignored
//   reg_wdata_i    write data, only the low bits each register needs are used
//   pwm_o          registered PWM outputs, one per channel
//   period_done_o  one-cycle pulse per channel in its wrap cycle
//   irq_o          (only with PWM_MULTI_IRQ_EN) sticky per-channel wrap flag
//
// Optional feature: define PWM_MULTI_IRQ_EN to add irq_o.  Without it CTRL
// bit2 has no effect.
// ---------------------------------------------------------------------------
module pwm_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        reg_we_i,
  input  logic [$clog2(NUM_CH)+1:0]   reg_addr_i,
  input  logic [31:0]                 reg_wdata_i,
  output logic [NUM_CH-1:0]           pwm_o,
  output logic [NUM_CH-1:0]           period_done_o
`ifdef PWM_MULTI_IRQ_EN
  ,
  output logic [NUM_CH-1:0]           irq_o
`endif
);

  localparam int ADDR_W = $clog2(NUM_CH) + 2;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_DUTY   = 2'd2;
  localparam logic [1:0] REG_PRESC  = 2'd3;

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  logic [ADDR_W-1:0] wr_ch;
  logic [1:0]        wr_reg;
  logic              unused_wdata;

  // Channel index may exceed NUM_CH-1 when NUM_CH is not a power of two;
  // such an index simply matches no channel below, so the write is dropped.
  assign wr_ch        = reg_addr_i >> 2;
  assign wr_reg       = reg_addr_i[1:0];
  assign unused_wdata = ^reg_wdata_i;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic               sel;
    logic               en;
    logic               pol;
    logic [CNT_W-1:0]   pend_period;
    logic [CNT_W-1:0]   pend_duty;
    logic [PRESC_W-1:0] pend_presc;
    logic [CNT_W-1:0]   act_period;
    logic [CNT_W-1:0]   act_duty;
    logic [PRESC_W-1:0] act_presc;
    logic [CNT_W-1:0]   cnt;
    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;
    logic               wrap;
    logic               raw;
    logic               pwm_q;

    assign sel = reg_we_i && (wr_ch == ADDR_W'(g));

    // Comparisons use >= so a counter left beyond a terminal value can never
    // run away; in normal operation they behave as equality.
    assign tick = en && (presc_cnt >= act_presc);
    assign wrap = tick && (act_period != '0) && (cnt >= act_period - CNT_ONE);
    assign raw  = en && (act_period != '0) && (cnt < act_duty);

    // Register file: control bits and pending shadows.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        en          <= 1'b0;
        pol         <= 1'b0;
        pend_period <= '0;
        pend_duty   <= '0;
        pend_presc  <= '0;
      end else if (sel) begin
        case (wr_reg)
          REG_CTRL: begin
            en  <= reg_wdata_i[0];
            pol <= reg_wdata_i[1];
          end
          REG_PERIOD: pend_period <= reg_wdata_i[CNT_W-1:0];
          REG_DUTY:   pend_duty   <= reg_wdata_i[CNT_W-1:0];
          REG_PRESC:  pend_presc  <= reg_wdata_i[PRESC_W-1:0];
          default: ;
        endcase
      end
    end

    // Active copies follow the pending shadows while disabled, so enabling
    // starts with fresh values.  At a wrap they take the pending value as it
    // stood before this cycle's write, which defers a wrap-cycle write by
    // one full period.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        act_period <= '0;
        act_duty   <= '0;
        act_presc  <= '0;
      end else if (!en || wrap) begin
        act_period <= pend_period;
        act_duty   <= pend_duty;
        act_presc  <= pend_presc;
      end
    end

    // Prescaler and period counter, parked at zero while disabled or while
    // the period is zero.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt       <= '0;
        presc_cnt <= '0;
      end else if (!en || (act_period == '0)) begin
        cnt       <= '0;
        presc_cnt <= '0;
      end else if (tick) begin
        presc_cnt <= '0;
        cnt       <= wrap ? '0 : cnt + CNT_ONE;
      end else begin
        presc_cnt <= presc_cnt + PRESC_ONE;
      end
    end

    // Output register; when disabled raw is 0 so the pin sits at POL.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        pwm_q <= 1'b0;
      end else begin
        pwm_q <= raw ^ pol;
      end
    end

    assign pwm_o[g]         = pwm_q;
    assign period_done_o[g] = wrap;

`ifdef PWM_MULTI_IRQ_EN
    logic irq_q;
    logic irq_clr;

    assign irq_clr = sel && (wr_reg == REG_CTRL) && reg_wdata_i[2];

    // A wrap in the same cycle as a clear keeps the flag set so no event is lost.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        irq_q <= 1'b0;
      end else if (wrap) begin
        irq_q <= 1'b1;
      end else if (irq_clr) begin
        irq_q <= 1'b0;
      end
    end

    assign irq_o[g] = irq_q;
`endif
  end

endmodule
